// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver:
// frame states, data width, default filter and timeout settings.
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS         = 8;
    localparam int DEFAULT_FILTER_LEN    = 16;
    localparam int DEFAULT_TIMEOUT_TICKS = 32;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability counter for one PS/2 line.
// Emits a one-cycle pulse when the filtered level falls.
module ps2_line_filter
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1;
    logic          s2;
    logic          filt;
    logic [CW-1:0] cnt;

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            fall <= 1'b0;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= s2;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 front end: deglitches the pins, deserializes 11-bit
// frames, checks start/parity/stop and strobes out each good byte.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN    = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sixus,
    input  logic                     ps2_clk_in,
    input  logic                     ps2_dat_in,
    output logic [PS2_DATA_BITS-1:0] rx_dat,
    output logic                     rx_stb,
    output logic                     rx_err,
    output logic                     busy
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    ps2_state_t               state;
    logic                     fe;
    logic                     dat_s1;
    logic                     dat_s;
    logic [2:0]               bitcnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     par_ok;
    logic [TW-1:0]            tcnt;
    logic                     timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (ps2_clk_in),
        .fall (fe)
    );

    // Data only needs synchronizing; it is sampled long after it settles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dat_s1 <= 1'b1;
            dat_s  <= 1'b1;
        end else begin
            dat_s1 <= ps2_dat_in;
            dat_s  <= dat_s1;
        end
    end

    assign timeout = (state != ST_IDLE) && !fe && sixus && (tcnt == TW'(TIMEOUT_TICKS - 1));
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par_ok <= 1'b0;
            tcnt   <= '0;
            rx_dat <= '0;
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            rx_err <= 1'b0;

            if (state == ST_IDLE || fe) begin
                tcnt <= '0;
            end else if (sixus) begin
                tcnt <= tcnt + TW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (fe && !dat_s) begin
                        state  <= ST_DATA;
                        bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fe) begin
                        shreg  <= {dat_s, shreg[PS2_DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fe) begin
                        par_ok <= odd_parity_ok(shreg, dat_s);
                        state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fe) begin
                        if (dat_s && par_ok) begin
                            rx_dat <= shreg;
                            rx_stb <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A stalled keyboard abandons the partial frame.
            if (timeout) begin
                rx_err <= 1'b1;
                state  <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: good frames, bad parity/stop,
// timeout, clock glitches and mid-frame reset.
module tb_ps2_keyboard_rx;

    localparam int F    = 16;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sixus = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_div = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int stb_cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    int last_fall = 0;
    int overlap = 0;
    logic [7:0] stb_q[$];

    ps2_keyboard_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sixus     (sixus),
        .ps2_clk_in(ps2_clk),
        .ps2_dat_in(ps2_dat),
        .rx_dat    (rx_dat),
        .rx_stb    (rx_stb),
        .rx_err    (rx_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the clock block's periodic tick, one pulse every 10 cycles.
    always @(negedge clk) begin
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        sixus = (tick_div == 0);
    end

    always @(negedge clk) begin
        if (rx_stb) begin
            stb_cnt++;
            stb_cyc = cyc;
            stb_q.push_back(rx_dat);
        end
        if (rx_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rx_stb && rx_err) overlap++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, input logic glitch);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = frame[i];
            if (glitch && i == 4) begin
                repeat (10) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (10) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 20) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            if (i == 10) fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic clk_glitch(input int width);
        ps2_clk = 1'b0;
        repeat (width) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        int s0;
        int e0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check_output("reset_dat", rx_dat, 8'h00);
        check_output("reset_stb", rx_stb, 1'b0);
        check_output("reset_err", rx_err, 1'b0);
        check_output("reset_busy", busy, 1'b0);

        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check_output("good_stb_cnt", stb_cnt, 1);
        check_output("good_dat", rx_dat, 8'h1C);
        check_output("good_latency", stb_cyc - fall_cyc, 2 + F + 1);
        check_output("good_no_err", err_cnt, 0);
        check_output("good_busy", busy, 1'b0);

        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        check_output("par_err", err_cnt, 1);
        check_output("par_no_stb", stb_cnt, 1);
        check_output("par_dat_held", rx_dat, 8'h1C);

        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check_output("stop_err", err_cnt, 2);
        check_output("stop_no_stb", stb_cnt, 1);

        send_frame(8'h1C, 1'b0, 1'b0, 6, 1'b0);
        check_output("to_busy_before", busy, 1'b1);
        for (int k = 0; k < 1000 && err_cnt == 2; k++) @(negedge clk);
        check_output("to_err", err_cnt, 3);
        check_output("to_window", (err_cyc - last_fall >= 320) && (err_cyc - last_fall <= 350), 1'b1);
        check_output("to_busy_after", busy, 1'b0);
        check_output("to_no_stb", stb_cnt, 1);

        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
        check_output("f0_stb_cnt", stb_cnt, 2);
        check_output("f0_dat", rx_dat, 8'hF0);

        clk_glitch(10);
        clk_glitch(F - 1);
        check_output("glitch_idle_busy", busy, 1'b0);
        check_output("glitch_idle_err", err_cnt, 3);
        check_output("glitch_idle_stb", stb_cnt, 2);

        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1);
        check_output("glitch_mid_stb", stb_cnt, 3);
        check_output("glitch_mid_dat", rx_dat, 8'h5A);
        check_output("glitch_mid_err", err_cnt, 3);

        send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0);
        check_output("rst_busy_before", busy, 1'b1);
        s0 = stb_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_output("rst_busy_after", busy, 1'b0);
        check_output("rst_dat", rx_dat, 8'h00);
        check_output("rst_no_stb", stb_cnt, s0);
        check_output("rst_no_err", err_cnt, e0);

        send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b0);
        repeat (100) @(negedge clk);
        send_frame(8'h75, 1'b0, 1'b0, 11, 1'b0);
        check_output("pair_stb_cnt", stb_cnt, s0 + 2);
        check_output("pair_first", (stb_q.size() >= 2) ? stb_q[stb_q.size() - 2] : 8'hXX, 8'hE0);
        check_output("pair_second", (stb_q.size() >= 1) ? stb_q[stb_q.size() - 1] : 8'hXX, 8'h75);
        check_output("pair_no_err", err_cnt, e0);

        check_output("stb_err_exclusive", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
